// File: rtl/act_skew_feeder_pkg.sv
// act_skew_feeder_pkg: shared state codes and default geometry for the activation skew feeder.
package act_skew_feeder_pkg;
  localparam int DATASIZE_DEF = 8;
  localparam int ROWS_DEF = 4;
  localparam int CNTW_DEF = 16;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/act_skew_feeder_delay_line.sv
// act_delay_line: DEPTH-stage register chain with sync reset; DEPTH=0 degenerates to a wire.
module act_delay_line #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign q_o = d_i;
  end else begin : g_reg
    logic [WIDTH-1:0] pipe_q [DEPTH];
    always_ff @(posedge clk) begin
      if (rst) pipe_q <= '{default: '0};
      else begin
        pipe_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign q_o = pipe_q[DEPTH-1];
  end
endmodule

// File: rtl/act_skew_feeder.sv
// act_skew_feeder: registers one activation vector per handshake and skews row r by r cycles.
// Optional per-pass vector counter on vec_count when ACT_SKEW_CNT_EN is defined.
module act_skew_feeder
  import act_skew_feeder_pkg::*;
#(
  parameter int DATASIZE = DATASIZE_DEF,
  parameter int ROWS = ROWS_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ROWS*DATASIZE-1:0] in_act,
  input  logic                     in_last,
  output logic [ROWS*DATASIZE-1:0] out_act,
  output logic [ROWS-1:0]          out_valid_vec,
  output logic                     busy,
  output logic                     done
`ifdef ACT_SKEW_CNT_EN
  ,
  output logic [CNTW-1:0]          vec_count
`endif
);
  localparam int CW = $clog2(ROWS) + 1;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic vld_q;
  logic [ROWS*DATASIZE-1:0] act_q;
  logic acc;
  assign acc = in_valid & in_ready;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    in_ready = (state_q == IDLE) || (state_q == RUN);
    busy = state_q != IDLE;
    done = state_q == DONE;
    case (state_q)
      IDLE, RUN: if (acc) begin
        state_d = !in_last ? RUN : (ROWS > 1) ? DRAIN : DONE;
        cnt_d = CW'(ROWS > 1 ? ROWS - 2 : 0);
      end
      DRAIN: begin
        state_d = (cnt_q == '0) ? DONE : DRAIN;
        cnt_d = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      vld_q <= 1'b0;
      act_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      vld_q <= acc;
      act_q <= acc ? in_act : '0;
    end
  end
  // Input register gives every row the common +1; row r adds r more stages.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    act_delay_line #(.WIDTH(DATASIZE + 1), .DEPTH(r)) u_dl (
      .clk(clk),
      .rst(rst),
      .d_i({vld_q, act_q[r*DATASIZE +: DATASIZE]}),
      .q_o({out_valid_vec[r], out_act[r*DATASIZE +: DATASIZE]})
    );
  end
`ifdef ACT_SKEW_CNT_EN
  logic [CNTW-1:0] vcnt_q, vcnt_d;
  always_comb vcnt_d = !acc ? vcnt_q : (state_q == IDLE) ? CNTW'(1) : (&vcnt_q) ? vcnt_q : vcnt_q + 1'b1;
  always_ff @(posedge clk) vcnt_q <= rst ? '0 : vcnt_d;
  assign vec_count = vcnt_q;
`endif
endmodule

// File: tb/tb_act_skew_feeder.sv
// tb_act_skew_feeder: table-driven check of skew, bubbles, drain backpressure, reset and optional vec_count.
module tb_act_skew_feeder;
  logic clk = 1'b0, rst, in_valid, in_last, in_ready, busy, done;
  logic [31:0] in_act, out_act;
  logic [3:0] out_valid_vec;
`ifdef ACT_SKEW_CNT_EN
  logic [15:0] vec_count;
`endif
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  act_skew_feeder #(.DATASIZE(8), .ROWS(4), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act),
    .in_last(in_last), .out_act(out_act), .out_valid_vec(out_valid_vec), .busy(busy), .done(done)
`ifdef ACT_SKEW_CNT_EN
    , .vec_count(vec_count)
`endif
  );
  typedef struct packed {
    logic v, l;
    logic [31:0] act, eact;
    logic [3:0] evv;
    logic ebusy, edone, erdy;
  } vec_t;
  vec_t tbl [26];
  function automatic vec_t mk(logic v, logic l, logic [31:0] act, logic [31:0] eact, logic [3:0] evv,
                              logic eb, logic ed, logic er);
    return '{v: v, l: l, act: act, eact: eact, evv: evv, ebusy: eb, edone: ed, erdy: er};
  endfunction
  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tbl[0]  = mk(1, 1, 32'h04030201, 32'h00000000, 4'b0000, 0, 0, 1);
    tbl[1]  = mk(0, 0, 32'h0,        32'h00000001, 4'b0001, 1, 0, 0);
    tbl[2]  = mk(0, 0, 32'h0,        32'h00000200, 4'b0010, 1, 0, 0);
    tbl[3]  = mk(0, 0, 32'h0,        32'h00030000, 4'b0100, 1, 0, 0);
    tbl[4]  = mk(0, 0, 32'h0,        32'h04000000, 4'b1000, 1, 1, 0);
    tbl[5]  = mk(1, 0, 32'hA4A3A2A1, 32'h00000000, 4'b0000, 0, 0, 1);
    tbl[6]  = mk(0, 0, 32'h0,        32'h000000A1, 4'b0001, 1, 0, 1);
    tbl[7]  = mk(1, 1, 32'hB4B3B2B1, 32'h0000A200, 4'b0010, 1, 0, 1);
    tbl[8]  = mk(0, 0, 32'h0,        32'h00A300B1, 4'b0101, 1, 0, 0);
    tbl[9]  = mk(0, 0, 32'h0,        32'hA400B200, 4'b1010, 1, 0, 0);
    tbl[10] = mk(0, 0, 32'h0,        32'h00B30000, 4'b0100, 1, 0, 0);
    tbl[11] = mk(0, 0, 32'h0,        32'hB4000000, 4'b1000, 1, 1, 0);
    tbl[12] = mk(1, 0, 32'hC4C3C2C1, 32'h00000000, 4'b0000, 0, 0, 1);
    tbl[13] = mk(1, 0, 32'hD4D3D2D1, 32'h000000C1, 4'b0001, 1, 0, 1);
    tbl[14] = mk(1, 1, 32'hE4E3E2E1, 32'h0000C2D1, 4'b0011, 1, 0, 1);
    tbl[15] = mk(1, 1, 32'hF4F3F2F1, 32'h00C3D2E1, 4'b0111, 1, 0, 0);
    tbl[16] = mk(1, 1, 32'hF4F3F2F1, 32'hC4D3E200, 4'b1110, 1, 0, 0);
    tbl[17] = mk(1, 1, 32'hF4F3F2F1, 32'hD4E30000, 4'b1100, 1, 0, 0);
    tbl[18] = mk(1, 1, 32'hF4F3F2F1, 32'hE4000000, 4'b1000, 1, 1, 0);
    tbl[19] = mk(1, 1, 32'hF4F3F2F1, 32'h00000000, 4'b0000, 0, 0, 1);
    tbl[20] = mk(0, 0, 32'h0,        32'h000000F1, 4'b0001, 1, 0, 0);
    tbl[21] = mk(0, 1, 32'h0,        32'h0000F200, 4'b0010, 1, 0, 0);
    tbl[22] = mk(0, 1, 32'h0,        32'h00F30000, 4'b0100, 1, 0, 0);
    tbl[23] = mk(0, 1, 32'h0,        32'hF4000000, 4'b1000, 1, 1, 0);
    tbl[24] = mk(0, 1, 32'h0,        32'h00000000, 4'b0000, 0, 0, 1);
    tbl[25] = mk(0, 0, 32'h0,        32'h00000000, 4'b0000, 0, 0, 1);
    rst = 1; in_valid = 0; in_last = 0; in_act = '0;
    tick; tick;
    rst = 0;
    for (int i = 0; i < 26; i++) begin
      in_valid = tbl[i].v; in_last = tbl[i].l; in_act = tbl[i].act;
      chk($sformatf("c%0d_act", i), 64'(out_act), 64'(tbl[i].eact));
      chk($sformatf("c%0d_vv", i), 64'(out_valid_vec), 64'(tbl[i].evv));
      chk($sformatf("c%0d_busy", i), 64'(busy), 64'(tbl[i].ebusy));
      chk($sformatf("c%0d_done", i), 64'(done), 64'(tbl[i].edone));
      chk($sformatf("c%0d_ready", i), 64'(in_ready), 64'(tbl[i].erdy));
      tick;
    end
    in_valid = 1; in_last = 0; in_act = 32'h11223344;
    tick;
    in_act = 32'h55667788;
    tick;
    rst = 1;
    tick; tick; tick;
    rst = 0; in_valid = 0;
    chk("rst_act", 64'(out_act), 64'h0);
    chk("rst_vv", 64'(out_valid_vec), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_ready", 64'(in_ready), 64'h1);
    tick;
    chk("rst_flush_act", 64'(out_act), 64'h0);
    chk("rst_flush_vv", 64'(out_valid_vec), 64'h0);
`ifdef ACT_SKEW_CNT_EN
    chk("cnt_rst", 64'(vec_count), 64'h0);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1; in_last = (k == 4); in_act = 32'(k);
      tick;
    end
    in_valid = 0; in_last = 0;
    for (int n = 0; n < 10 && !done; n++) tick;
    chk("cnt_done_seen", 64'(done), 64'h1);
    chk("cnt_at_done", 64'(vec_count), 64'd5);
    tick;
    in_valid = 1;
    tick;
    chk("cnt_first", 64'(vec_count), 64'd1);
    in_last = 1;
    tick;
    chk("cnt_second", 64'(vec_count), 64'd2);
    in_valid = 0; in_last = 0;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
